// File: rtl/vpifo_task_dispatcher.sv
// -----------------------------------------------------------------------------
// vpifo_task_dispatcher
//
// Multi-port injection front end for the virtualised PIFO tree. Each ingress
// port owns a small task FIFO. The head of every FIFO is routed to the RPU
// selected by the low bits of its tree id. Each RPU has its own round-robin
// arbiter over the ports, and an RPU that is busy with ring traffic grants
// nothing that cycle. The granted heads are popped and registered onto the
// o_rpu_* injection slots.
//
// Optional feature (compile-time macro): VPIFO_TREE_CREDIT_EN
//   Adds a per-tree occupancy counter (CTW bits). Pops to an empty tree and
//   pushes to a saturated tree are consumed but not forwarded, and they are
//   counted as drops. Without the macro every dispatched op is forwarded.
//
// Ports
//   i_clk, i_arst     clock, asynchronous active-high reset
//   i_push / i_pop    per-port request (push and pop together = dropped)
//   i_tree_id         per-port target tree, port p at [p*TNB +: TNB]
//   i_push_data       per-port payload, port p at [p*DW +: DW]
//   o_fifo_full       per-port FIFO full flag
//   o_fifo_cnt        per-port FIFO occupancy, port p at [p*(FAW+1) +: FAW+1]
//   o_drop_cnt        saturating count of discarded requests
//   i_rpu_busy        per-RPU "slot taken by ring traffic" (blocks injection)
//   o_rpu_push/pop    per-RPU registered injection op
//   o_rpu_tree_id     per-RPU tree id (0 when idle)
//   o_rpu_push_data   per-RPU payload (all ones unless a push is injected)
// -----------------------------------------------------------------------------
module vpifo_task_dispatcher #(
    parameter int PTW        = 16,
    parameter int MTW        = 0,
    parameter int TREE_NUM   = 8,
    parameter int LEVEL      = 4,
    parameter int PORTS      = 4,
    parameter int FIFO_DEPTH = 8
`ifdef VPIFO_TREE_CREDIT_EN
    ,
    parameter int CTW        = 10
`endif
) (
    input  logic                                       i_clk,
    input  logic                                       i_arst,
    input  logic [PORTS-1:0]                           i_push,
    input  logic [PORTS-1:0]                           i_pop,
    input  logic [PORTS*$clog2(TREE_NUM)-1:0]          i_tree_id,
    input  logic [PORTS*(PTW+MTW)-1:0]                 i_push_data,
    output logic [PORTS-1:0]                           o_fifo_full,
    output logic [PORTS*($clog2(FIFO_DEPTH)+1)-1:0]    o_fifo_cnt,
    output logic [15:0]                                o_drop_cnt,
    input  logic [LEVEL-1:0]                           i_rpu_busy,
    output logic [LEVEL-1:0]                           o_rpu_push,
    output logic [LEVEL-1:0]                           o_rpu_pop,
    output logic [LEVEL*$clog2(TREE_NUM)-1:0]          o_rpu_tree_id,
    output logic [LEVEL*(PTW+MTW)-1:0]                 o_rpu_push_data
);
    localparam int DW  = PTW + MTW;
    localparam int TNB = $clog2(TREE_NUM);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int LW  = $clog2(LEVEL);
    localparam int PW  = (PORTS > 1) ? $clog2(PORTS) : 1;
    // Entry layout: [EW-1] op (1 = push), [DW +: TNB] tree id, [DW-1:0] data
    localparam int EW  = 1 + TNB + DW;
    localparam logic [FAW:0] FULL_CNT = (FAW+1)'(FIFO_DEPTH);

    logic [EW-1:0]    head [PORTS];
    logic [PORTS-1:0] head_valid;
    logic [PORTS-1:0] deq;
    logic [PORTS-1:0] req_drop;

    logic [LEVEL-1:0] gnt_valid;
    logic [LEVEL-1:0] fwd;
    logic [PW-1:0]    gnt_port  [LEVEL];
    logic [EW-1:0]    gnt_entry [LEVEL];
    logic [PW-1:0]    rr_reg    [LEVEL];
    logic [PW-1:0]    rr_next   [LEVEL];

    logic [15:0]      drop_cnt_reg;
    logic [15:0]      drop_cnt_next;
    logic [16:0]      drop_sum;

    // -------------------------------------------------------------------------
    // Per-port task FIFOs. The head is read combinationally so the arbiters
    // can see it in the same cycle it becomes valid.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_port
            logic [EW-1:0]  fifo_mem [FIFO_DEPTH];
            logic [FAW-1:0] wr_ptr_reg;
            logic [FAW-1:0] rd_ptr_reg;
            logic [FAW:0]   cnt_reg;
            logic           push;
            logic           pop;
            logic           full;
            logic           enq;
            logic [EW-1:0]  entry_in;

            assign push = i_push[gi];
            assign pop  = i_pop[gi];
            assign full = (cnt_reg == FULL_CNT);

            // A full FIFO still accepts when its head leaves in the same cycle.
            assign enq          = (push ^ pop) & (~full | deq[gi]);
            assign req_drop[gi] = (push & pop) | ((push ^ pop) & full & ~deq[gi]);

            assign entry_in = push ? {1'b1, i_tree_id[gi*TNB +: TNB], i_push_data[gi*DW +: DW]}
                                   : {1'b0, i_tree_id[gi*TNB +: TNB], {DW{1'b0}}};

            assign head[gi]       = fifo_mem[rd_ptr_reg];
            assign head_valid[gi] = (cnt_reg != '0);

            assign o_fifo_full[gi]                    = full;
            assign o_fifo_cnt[gi*(FAW+1) +: (FAW+1)]  = cnt_reg;

            always_ff @(posedge i_clk) begin
                if (enq) begin
                    fifo_mem[wr_ptr_reg] <= entry_in;
                end
            end

            always_ff @(posedge i_clk or posedge i_arst) begin
                if (i_arst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else begin
                    if (enq) begin
                        wr_ptr_reg <= wr_ptr_reg + FAW'(1);
                    end
                    if (deq[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + FAW'(1);
                    end
                    if (enq && !deq[gi]) begin
                        cnt_reg <= cnt_reg + (FAW+1)'(1);
                    end else if (!enq && deq[gi]) begin
                        cnt_reg <= cnt_reg - (FAW+1)'(1);
                    end
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Per-RPU round-robin arbitration. Each head targets exactly one RPU, so
    // the grants of different RPUs never select the same port.
    // -------------------------------------------------------------------------
    always_comb begin
        int p;
        p = 0;
        for (int r = 0; r < LEVEL; r++) begin
            gnt_valid[r] = 1'b0;
            gnt_port[r]  = '0;
            rr_next[r]   = rr_reg[r];
            for (int i = 0; i < PORTS; i++) begin
                p = (int'(rr_reg[r]) + i) % PORTS;
                if (!gnt_valid[r] && !i_rpu_busy[r] && head_valid[p] &&
                    (head[p][DW +: LW] == LW'(r))) begin
                    gnt_valid[r] = 1'b1;
                    gnt_port[r]  = PW'(p);
                    rr_next[r]   = PW'((p + 1) % PORTS);
                end
            end
            gnt_entry[r] = head[gnt_port[r]];
        end
    end

    always_comb begin
        deq = '0;
        for (int r = 0; r < LEVEL; r++) begin
            if (gnt_valid[r]) begin
                deq[gnt_port[r]] = 1'b1;
            end
        end
    end

`ifdef VPIFO_TREE_CREDIT_EN
    // Per-tree occupancy. A tree maps to a single RPU, so at most one update
    // per tree per cycle.
    logic [CTW-1:0] cred_reg [TREE_NUM];

    always_comb begin
        for (int r = 0; r < LEVEL; r++) begin
            fwd[r] = gnt_valid[r];
            if (gnt_valid[r]) begin
                if (gnt_entry[r][EW-1]) begin
                    if (cred_reg[gnt_entry[r][DW +: TNB]] == '1) begin
                        fwd[r] = 1'b0;
                    end
                end else begin
                    if (cred_reg[gnt_entry[r][DW +: TNB]] == '0) begin
                        fwd[r] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            for (int t = 0; t < TREE_NUM; t++) begin
                cred_reg[t] <= '0;
            end
        end else begin
            for (int r = 0; r < LEVEL; r++) begin
                if (fwd[r]) begin
                    if (gnt_entry[r][EW-1]) begin
                        cred_reg[gnt_entry[r][DW +: TNB]] <= cred_reg[gnt_entry[r][DW +: TNB]] + CTW'(1);
                    end else begin
                        cred_reg[gnt_entry[r][DW +: TNB]] <= cred_reg[gnt_entry[r][DW +: TNB]] - CTW'(1);
                    end
                end
            end
        end
    end
`else
    assign fwd = gnt_valid;
`endif

    // -------------------------------------------------------------------------
    // Drop accounting: enqueue-side discards plus dispatched-but-not-forwarded
    // ops, summed and saturated at 16'hFFFF.
    // -------------------------------------------------------------------------
    always_comb begin
        drop_sum = {1'b0, drop_cnt_reg};
        for (int p = 0; p < PORTS; p++) begin
            drop_sum = drop_sum + 17'(req_drop[p]);
        end
        for (int r = 0; r < LEVEL; r++) begin
            drop_sum = drop_sum + 17'(gnt_valid[r] & ~fwd[r]);
        end
        drop_cnt_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign o_drop_cnt = drop_cnt_reg;

    // -------------------------------------------------------------------------
    // Registered injection slots and arbiter pointers.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_rpu_push      <= '0;
            o_rpu_pop       <= '0;
            o_rpu_tree_id   <= '0;
            o_rpu_push_data <= '1;
            drop_cnt_reg    <= '0;
            for (int r = 0; r < LEVEL; r++) begin
                rr_reg[r] <= '0;
            end
        end else begin
            drop_cnt_reg <= drop_cnt_next;
            for (int r = 0; r < LEVEL; r++) begin
                rr_reg[r]                   <= rr_next[r];
                o_rpu_push[r]               <= fwd[r] & gnt_entry[r][EW-1];
                o_rpu_pop[r]                <= fwd[r] & ~gnt_entry[r][EW-1];
                o_rpu_tree_id[r*TNB +: TNB] <= fwd[r] ? gnt_entry[r][DW +: TNB] : '0;
                o_rpu_push_data[r*DW +: DW] <= (fwd[r] && gnt_entry[r][EW-1]) ? gnt_entry[r][DW-1:0]
                                                                            : {DW{1'b1}};
            end
        end
    end

endmodule

// File: tb/tb_vpifo_task_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_vpifo_task_dispatcher
//
// Directed bench for vpifo_task_dispatcher with default parameters
// (PTW=16, MTW=0, TREE_NUM=8, LEVEL=4, PORTS=4, FIFO_DEPTH=8), default build.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_vpifo_task_dispatcher;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  push;
    logic [3:0]  pop;
    logic [11:0] tree_id;
    logic [63:0] push_data;
    logic [3:0]  full;
    logic [15:0] fifo_cnt;
    logic [15:0] drop_cnt;
    logic [3:0]  busy;
    logic [3:0]  rpu_push;
    logic [3:0]  rpu_pop;
    logic [11:0] rpu_tree;
    logic [63:0] rpu_data;

    int n_cmp = 0;
    int n_err = 0;

    vpifo_task_dispatcher dut (
        .i_clk           (clk),
        .i_arst          (rst),
        .i_push          (push),
        .i_pop           (pop),
        .i_tree_id       (tree_id),
        .i_push_data     (push_data),
        .o_fifo_full     (full),
        .o_fifo_cnt      (fifo_cnt),
        .o_drop_cnt      (drop_cnt),
        .i_rpu_busy      (busy),
        .o_rpu_push      (rpu_push),
        .o_rpu_pop       (rpu_pop),
        .o_rpu_tree_id   (rpu_tree),
        .o_rpu_push_data (rpu_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic [2:0] t, input logic [15:0] d);
        push[p]              = 1'b1;
        tree_id[p*3 +: 3]    = t;
        push_data[p*16 +: 16] = d;
    endtask

    task automatic clr();
        push      = '0;
        pop       = '0;
        tree_id   = '0;
        push_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        busy = '0;
        rst  = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_push", {60'd0, rpu_push}, 64'd0);
        chk("rst_pop", {60'd0, rpu_pop}, 64'd0);
        chk("rst_tree", {52'd0, rpu_tree}, 64'd0);
        chk("rst_data", rpu_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_cnt", {48'd0, fifo_cnt}, 64'd0);
        chk("rst_full", {60'd0, full}, 64'd0);
        chk("rst_drop", {48'd0, drop_cnt}, 64'd0);
        rst = 1'b0;
        step();
        chk("rst_idle", {60'd0, rpu_push}, 64'd0);

        // T1: single op, port0 push tree 5 -> RPU1 two edges later
        drive(0, 3'd5, 16'h1234);
        step();
        clr();
        chk("t1_early", {60'd0, rpu_push}, 64'd0);
        chk("t1_cnt", {60'd0, fifo_cnt[3:0]}, 64'd1);
        step();
        chk("t1_push", {60'd0, rpu_push}, 64'h2);
        chk("t1_tree", {52'd0, rpu_tree}, 64'h028);
        chk("t1_data", rpu_data, 64'hFFFF_FFFF_1234_FFFF);
        chk("t1_cnt0", {60'd0, fifo_cnt[3:0]}, 64'd0);
        step();
        chk("t1_after", {60'd0, rpu_push}, 64'd0);

        // T2: round robin on RPU2, three pushes queued per port
        busy = 4'b0100;
        for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < 4; p++) begin
                drive(p, 3'd2, 16'(p * 16 + s));
            end
            step();
        end
        clr();
        chk("t2_load_cnt", {48'd0, fifo_cnt}, 64'h3333);
        chk("t2_load_idle", {60'd0, rpu_push}, 64'd0);
        busy = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("t2_push", {60'd0, rpu_push}, 64'h4);
            chk("t2_data", {48'd0, rpu_data[47:32]}, 64'((i % 4) * 16 + i / 4));
        end
        step();
        chk("t2_idle", {60'd0, rpu_push}, 64'd0);
        chk("t2_cnt", {48'd0, fifo_cnt}, 64'd0);

        // T3: backpressure on RPU3 for five edges
        busy = 4'b1000;
        drive(1, 3'd3, 16'hBEEF);
        for (int i = 0; i < 5; i++) begin
            step();
            clr();
            chk("t3_blocked", {63'd0, rpu_push[3]}, 64'd0);
            chk("t3_cnt", {60'd0, fifo_cnt[7:4]}, 64'd1);
        end
        busy = '0;
        step();
        chk("t3_push", {60'd0, rpu_push}, 64'h8);
        chk("t3_data", {48'd0, rpu_data[63:48]}, 64'hBEEF);
        chk("t3_tree", {61'd0, rpu_tree[11:9]}, 64'd3);
        chk("t3_cnt0", {60'd0, fifo_cnt[7:4]}, 64'd0);

        // T4: full FIFO, push&pop collision, enqueue while full head leaves
        busy = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            drive(0, 3'd0, 16'(16'hA000 + i));
            step();
        end
        clr();
        chk("t4_cnt8", {60'd0, fifo_cnt[3:0]}, 64'd8);
        chk("t4_full", {60'd0, full}, 64'h1);
        chk("t4_drop0", {48'd0, drop_cnt}, 64'd0);
        drive(0, 3'd0, 16'hDEAD);
        step();
        clr();
        chk("t4_ovf_cnt", {60'd0, fifo_cnt[3:0]}, 64'd8);
        chk("t4_ovf_drop", {48'd0, drop_cnt}, 64'd1);
        drive(2, 3'd0, 16'h0BAD);
        pop[2] = 1'b1;
        step();
        clr();
        chk("t4_pp_drop", {48'd0, drop_cnt}, 64'd2);
        chk("t4_pp_cnt", {60'd0, fifo_cnt[11:8]}, 64'd0);
        busy = '0;
        drive(0, 3'd0, 16'hA008);
        step();
        clr();
        chk("t4_sim_push", {60'd0, rpu_push}, 64'h1);
        chk("t4_sim_data", {48'd0, rpu_data[15:0]}, 64'hA000);
        chk("t4_sim_cnt", {60'd0, fifo_cnt[3:0]}, 64'd8);
        chk("t4_sim_drop", {48'd0, drop_cnt}, 64'd2);
        for (int i = 0; i < 8; i++) begin
            step();
        end
        chk("t4_last_push", {60'd0, rpu_push}, 64'h1);
        chk("t4_last_data", {48'd0, rpu_data[15:0]}, 64'hA008);
        chk("t4_drained", {60'd0, fifo_cnt[3:0]}, 64'd0);
        step();
        chk("t4_idle", {60'd0, rpu_push}, 64'd0);

        // T5: parallel routing to all four RPUs, then a pop on tree 6
        drive(0, 3'd0, 16'h1000);
        drive(1, 3'd1, 16'h1111);
        drive(2, 3'd2, 16'h2222);
        drive(3, 3'd3, 16'h3333);
        step();
        clr();
        step();
        chk("t5_push", {60'd0, rpu_push}, 64'hF);
        chk("t5_tree", {52'd0, rpu_tree}, 64'h688);
        chk("t5_data", rpu_data, 64'h3333_2222_1111_1000);
        pop[3]        = 1'b1;
        tree_id[11:9] = 3'd6;
        step();
        clr();
        step();
        chk("t5_pop", {60'd0, rpu_pop}, 64'h4);
        chk("t5_pop_push", {60'd0, rpu_push}, 64'd0);
        chk("t5_pop_tree", {52'd0, rpu_tree}, 64'h180);
        chk("t5_pop_data", rpu_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t5_drop", {48'd0, drop_cnt}, 64'd2);

        // T6: asynchronous reset in the middle of traffic
        busy = 4'b0001;
        drive(0, 3'd0, 16'h7777);
        drive(1, 3'd1, 16'h5555);
        step();
        clr();
        step();
        chk("t6_pre_push", {60'd0, rpu_push}, 64'h2);
        chk("t6_pre_cnt", {60'd0, fifo_cnt[3:0]}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_push", {60'd0, rpu_push}, 64'd0);
        chk("t6_rst_tree", {52'd0, rpu_tree}, 64'd0);
        chk("t6_rst_data", rpu_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t6_rst_cnt", {48'd0, fifo_cnt}, 64'd0);
        chk("t6_rst_full", {60'd0, full}, 64'd0);
        chk("t6_rst_drop", {48'd0, drop_cnt}, 64'd0);
        rst  = 1'b0;
        busy = '0;
        step();
        chk("t6_post_push", {60'd0, rpu_push}, 64'd0);
        chk("t6_post_cnt", {48'd0, fifo_cnt}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
